// File: rtl/rope_swing_scheduler.sv
// rtl/rope_swing_scheduler.sv - per-rope direction-toggle scheduler serialized once per frame
//
// Purpose:
//   Each rope reverses direction on its own periodic frame timer or on a latched collision.
//   A per-rope cooldown discards collisions that arrive shortly after a toggle. Once per
//   enabled frame a sequencer visits the ropes in index order, one rope per clock, so every
//   rope state update is serialized and the emitted pulses are one-hot.
//
// Ports:
//   clk           in   1      system clock
//   resetN        in   1      asynchronous active-low reset
//   startOfFrame  in   1      one-cycle pulse at each frame start
//   enable        in   1      1 = frames start a scan, 0 = frames are skipped
//   collision     in   ROPES  level, bit i = rope i hit something this cycle
//   dirToggle     out  ROPES  registered one-hot single-cycle toggle pulse
//   busy          out  1      high while a scan is in progress
//   frameOverrun  out  1      one-cycle pulse, startOfFrame arrived while busy

module rope_swing_scheduler #(
    parameter int ROPES       = 6,
    parameter int BASE_PERIOD = 40,
    parameter int PERIOD_STEP = 8,
    parameter int COOLDOWN    = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             enable,
    input  logic [ROPES-1:0] collision,
    output logic [ROPES-1:0] dirToggle,
    output logic             busy,
    output logic             frameOverrun
);

    localparam int                IDX_W         = (ROPES > 1) ? $clog2(ROPES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(ROPES - 1);
    localparam logic [7:0]        COOLDOWN_INIT = 8'(COOLDOWN);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Toggle period of rope k in frames.
    function automatic logic [7:0] period_of(input int k);
        return 8'(BASE_PERIOD + k * PERIOD_STEP);
    endfunction

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;

    logic [ROPES-1:0]   pending_q;
    logic [ROPES-1:0]   pending_d;
    logic [7:0]         timer_q    [ROPES];
    logic [7:0]         cooldown_q [ROPES];
    logic [ROPES-1:0]   toggle_q;
    logic               overrun_q;

    logic               scanning;
    logic [ROPES-1:0]   visit_sel;
    logic               vis_pend;
    logic [7:0]         vis_timer;
    logic [7:0]         vis_cd;
    logic [7:0]         vis_period;
    logic [7:0]         cd_dec;
    logic [7:0]         new_timer;
    logic [7:0]         new_cd;
    logic               visit_toggle;

    assign scanning = (state_q == SCAN);

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                // A frame arriving while paused is simply dropped.
                if (startOfFrame && enable) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                // Frames arriving mid-scan never restart the sequence.
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Visit of the rope selected by idx
    // ------------------------------------------------------------------
    always_comb begin
        visit_sel        = '0;
        visit_sel[idx_q] = scanning;

        vis_pend   = pending_q[idx_q];
        vis_timer  = timer_q[idx_q];
        vis_cd     = cooldown_q[idx_q];
        vis_period = period_of(int'(idx_q));
        cd_dec     = (vis_cd == 8'd0) ? 8'd0 : vis_cd - 8'd1;

        visit_toggle = 1'b0;
        new_timer    = vis_timer;
        new_cd       = vis_cd;

        if (vis_pend && (vis_cd == 8'd0)) begin
            // Accepted collision: reverse now and restart the period.
            visit_toggle = 1'b1;
            new_timer    = vis_period;
            new_cd       = COOLDOWN_INIT;
        end else if (vis_timer == 8'd1) begin
            // Timer expiry; a collision discarded by cooldown lands here too.
            visit_toggle = 1'b1;
            new_timer    = vis_period;
            new_cd       = COOLDOWN_INIT;
        end else begin
            // Discarded collision or idle frame: both just age the rope by one frame.
            new_timer = vis_timer - 8'd1;
            new_cd    = cd_dec;
        end
    end

    // Collisions set pending every cycle; a visit clears it, but a same-cycle hit survives.
    assign pending_d = (pending_q & ~visit_sel) | collision;

    // ------------------------------------------------------------------
    // Per-rope state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pending_q <= '0;
            toggle_q  <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < ROPES; i++) begin
                timer_q[i]    <= period_of(i);
                cooldown_q[i] <= 8'd0;
            end
        end else begin
            pending_q <= pending_d;
            overrun_q <= startOfFrame & scanning;
            toggle_q  <= visit_toggle ? visit_sel : '0;
            if (scanning) begin
                timer_q[idx_q]    <= new_timer;
                cooldown_q[idx_q] <= new_cd;
            end
        end
    end

    assign dirToggle    = toggle_q;
    assign busy         = scanning;
    assign frameOverrun = overrun_q;

endmodule

// File: tb/tb_rope_swing_scheduler.sv
// tb/tb_rope_swing_scheduler.sv - scoreboard bench for rope_swing_scheduler

module tb_rope_swing_scheduler;

    localparam int ROPES = 6;

    typedef struct {
        int         cyc;
        logic [5:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       enable = 1'b1;
    logic [5:0] collision = 6'h3f;
    logic [5:0] dirToggle;
    logic       busy;
    logic       frameOverrun;

    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    exp_t exp_q[$];

    rope_swing_scheduler #(
        .ROPES(ROPES),
        .BASE_PERIOD(3),
        .PERIOD_STEP(1),
        .COOLDOWN(4)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .enable(enable),
        .collision(collision),
        .dirToggle(dirToggle),
        .busy(busy),
        .frameOverrun(frameOverrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: every nonzero dirToggle must match the oldest expected pulse, cycle and mask.
    always @(negedge clk) begin
        exp_t e;
        if (dirToggle !== 6'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_toggle: got %b at edge %0d, no pulse expected", dirToggle, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != edge_cnt || e.mask !== dirToggle) begin
                    failures++;
                    $display("FAIL toggle_pulse: got %b at edge %0d, expected %b at edge %0d",
                             dirToggle, edge_cnt, e.mask, e.cyc);
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    task automatic check_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing: %0d expected pulses not seen, first at edge %0d",
                     name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic apply_reset(input logic [5:0] col);
        @(negedge clk);
        resetN       = 1'b0;
        collision    = col;
        startOfFrame = 1'b0;
        enable       = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("reset_dirToggle", dirToggle, 6'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_overrun", frameOverrun, 1'b0);
        collision = 6'b0;
        @(negedge clk);
        resetN = 1'b1;
        exp_q.delete();
    endtask

    task automatic pulse_collision(input logic [5:0] m);
        @(negedge clk);
        collision = m;
        @(negedge clk);
        collision = 6'b0;
    endtask

    // One enabled frame; mask is the hand-computed set of ropes that toggle in it.
    task automatic run_frame(input string name, input logic [5:0] mask, input bit drop_en);
        int p0;
        @(negedge clk);
        startOfFrame = 1'b1;
        p0 = edge_cnt + 1;
        for (int k = 0; k < ROPES; k++)
            if (mask[k]) exp_q.push_back('{p0 + k + 1, 6'(1 << k)});
        for (int i = 0; i < ROPES + 2; i++) begin
            @(negedge clk);
            if (i == 0) begin
                startOfFrame = 1'b0;
                if (drop_en) enable = 1'b0;
            end
            check_bit({name, "_busy"}, busy, (i < ROPES));
        end
        enable = 1'b1;
        check_empty(name);
    endtask

    task automatic pause_frame();
        @(negedge clk);
        enable       = 1'b0;
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_bit("pause_busy", busy, 1'b0);
        end
    endtask

    // Second startOfFrame two cycles into the scan: overrun pulse, no restart.
    task automatic overrun_frame();
        @(negedge clk);
        startOfFrame = 1'b1;
        for (int i = 0; i < ROPES + 3; i++) begin
            @(negedge clk);
            startOfFrame = (i == 1);
            check_bit("ovr_busy", busy, (i < ROPES));
            check_bit("ovr_pulse", frameOverrun, (i == 2));
        end
        check_empty("ovr_frame");
    endtask

    logic [5:0] tbl_a [16] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h04, 6'h09, 6'h10, 6'h22,
                               6'h01, 6'h04, 6'h00, 6'h0b, 6'h00, 6'h10, 6'h05, 6'h22};

    initial begin
        int p0;

        // T1 + T2: reset with all collisions asserted, then 16 periodic frames.
        apply_reset(6'h3f);
        for (int f = 0; f < 16; f++) run_frame("periodic", tbl_a[f], 1'b0);

        // T3: accepted collision, then a collision discarded during cooldown.
        apply_reset(6'h00);
        run_frame("col_f1", 6'h00, 1'b0);
        pulse_collision(6'h04);
        run_frame("col_f2", 6'h04, 1'b0);
        run_frame("col_f3", 6'h01, 1'b0);
        pulse_collision(6'h04);
        run_frame("col_f4", 6'h02, 1'b0);
        run_frame("col_f5", 6'h00, 1'b0);
        run_frame("col_f6", 6'h09, 1'b0);
        run_frame("col_f7", 6'h14, 1'b0);
        run_frame("col_f8", 6'h22, 1'b0);

        // T4 + T5: all-rope hit, overrun, pause, enable drop mid-scan.
        apply_reset(6'h00);
        run_frame("hot_f1", 6'h00, 1'b0);
        pulse_collision(6'h3f);
        run_frame("hot_f2", 6'h3f, 1'b0);
        overrun_frame();
        run_frame("hot_f4", 6'h00, 1'b0);
        repeat (5) pause_frame();
        enable = 1'b1;
        run_frame("resume_f5", 6'h01, 1'b0);
        run_frame("endrop_f6", 6'h02, 1'b1);

        // T6: reset in the middle of a scan that is emitting pulses.
        apply_reset(6'h00);
        run_frame("mid_f1", 6'h00, 1'b0);
        run_frame("mid_f2", 6'h00, 1'b0);
        pulse_collision(6'h02);
        @(negedge clk);
        startOfFrame = 1'b1;
        p0 = edge_cnt + 1;
        exp_q.push_back('{p0 + 1, 6'h01});
        exp_q.push_back('{p0 + 2, 6'h02});
        @(negedge clk);
        startOfFrame = 1'b0;
        repeat (2) @(negedge clk);
        #1 resetN = 1'b0;
        #1;
        check_vec("midreset_dirToggle", dirToggle, 6'b0);
        check_bit("midreset_busy", busy, 1'b0);
        check_empty("midreset_pre");
        @(negedge clk);
        resetN = 1'b1;
        run_frame("post_f1", 6'h00, 1'b0);
        run_frame("post_f2", 6'h00, 1'b0);
        run_frame("post_f3", 6'h01, 1'b0);

        repeat (4) @(negedge clk);
        check_empty("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
